exe_dmem_req: RTL and testbench

- Issues the data-side memory request for the EXE stage and feeds the MEM stage.
- Drives the data_sram request channel, with req/addr_ok then data_ok. Aligns store data and byte strobes. Computes EXE ready_go from addr_ok.
- Counts in-flight requests. After an exception flush it discards stale data_ok responses, so MEM only sees data_ok/rdata for requests it still owns.

---
 rtl/exe_dmem_req_pkg.sv | 15 +
 rtl/dmem_store_align.sv | 34 +++
 rtl/exe_dmem_req.sv | 110 +++++++++++
 tb/tb_exe_dmem_req.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_dmem_req_pkg.sv
// Shared definitions for the EXE-stage data memory request path.
// Size codes, in-flight limits and the data_sram request bus width.
package exe_dmem_req_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam int DMEM_MAX_INFLIGHT = 2;
  localparam int DMEM_CNT_W        = 2;

  // req + wr + size + wstrb + addr + wdata
  localparam int DSRAM_REQ_W = 1 + 1 + 2 + 4 + 32 + 32;

endpackage

// File: rtl/dmem_store_align.sv
// Store alignment: byte strobes and lane-replicated store data.
// In: size_i, addr_lo_i, we_i, wdata_i. Out: wstrb_o, wdata_o.
module dmem_store_align
  import exe_dmem_req_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o
);

  always_comb begin
    wstrb_o = 4'b1111;
    wdata_o = wdata_i;
    unique case (1'b1)
      (size_i == SIZE_B): begin
        wstrb_o = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      (size_i == SIZE_H): begin
        wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: begin
        wstrb_o = 4'b1111;
        wdata_o = wdata_i;
      end
    endcase
    if (!we_i) wstrb_o = 4'b0000;
  end

endmodule

// File: rtl/exe_dmem_req.sv
// EXE-stage data_sram request issue, in-flight tracking, stale-response filter.
// Ports: EXE instr (exe_*_i), MEM handshake, flush, data_sram channel, MEM response.
module exe_dmem_req
  import exe_dmem_req_pkg::*;
#(
  parameter int MAX_INFLIGHT = DMEM_MAX_INFLIGHT,
  parameter int CNT_W        = DMEM_CNT_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exe_valid_i,
  input  logic        exe_mem_req_i,
  input  logic        exe_we_i,
  input  logic [1:0]  exe_size_i,
  input  logic [31:0] exe_addr_i,
  input  logic [31:0] exe_wdata_i,
  input  logic        mem_allowin_i,
  input  logic        excep_flush_i,
  output logic        data_sram_req_o,
  output logic        data_sram_wr_o,
  output logic [1:0]  data_sram_size_o,
  output logic [3:0]  data_sram_wstrb_o,
  output logic [31:0] data_sram_addr_o,
  output logic [31:0] data_sram_wdata_o,
  input  logic        data_sram_addr_ok_i,
  input  logic        data_sram_data_ok_i,
  input  logic [31:0] data_sram_rdata_i,
  output logic        exe_ready_go_o,
  output logic        mem_data_ok_o,
  output logic [31:0] mem_rdata_o
);

  logic             req_sent_q, req_sent_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] cancel_q, cancel_d;
  logic             fire, hand_off, room, cancel_idle;

  assign room        = (inflight_q < CNT_W'(MAX_INFLIGHT));
  assign cancel_idle = (cancel_q == '0);

  // rst_n gates the request so it drops the instant reset asserts,
  // even though the cleared counters would otherwise allow it.
  assign data_sram_req_o = rst_n & exe_valid_i & exe_mem_req_i
                         & ~req_sent_q & ~excep_flush_i
                         & room & cancel_idle;

  assign fire           = data_sram_req_o & data_sram_addr_ok_i;
  assign exe_ready_go_o = ~exe_mem_req_i | req_sent_q | fire;
  assign hand_off       = exe_valid_i & exe_ready_go_o & mem_allowin_i;

  assign data_sram_wr_o   = exe_we_i;
  assign data_sram_size_o = exe_size_i;
  assign data_sram_addr_o = exe_addr_i;

  dmem_store_align u_align (
    .size_i    (exe_size_i),
    .addr_lo_i (exe_addr_i[1:0]),
    .we_i      (exe_we_i),
    .wdata_i   (exe_wdata_i),
    .wstrb_o   (data_sram_wstrb_o),
    .wdata_o   (data_sram_wdata_o)
  );

  // Responses owed to flushed instructions are swallowed here.
  assign mem_data_ok_o = rst_n & data_sram_data_ok_i & cancel_idle;
  assign mem_rdata_o   = data_sram_rdata_i;

  always_comb begin
    req_sent_d = req_sent_q;
    if (excep_flush_i)
      req_sent_d = 1'b0;
    else if (hand_off)
      req_sent_d = 1'b0;
    else if (fire)
      req_sent_d = 1'b1;
  end

  always_comb begin
    inflight_d = inflight_q + CNT_W'(fire)
               - CNT_W'(data_sram_data_ok_i);
  end

  // A flush marks everything still outstanding as stale; a response
  // landing in the flush cycle itself is not counted.
  always_comb begin
    cancel_d = cancel_q;
    if (excep_flush_i)
      cancel_d = inflight_q - CNT_W'(data_sram_data_ok_i);
    else if (!cancel_idle && data_sram_data_ok_i)
      cancel_d = cancel_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_sent_q <= 1'b0;
      inflight_q <= '0;
      cancel_q   <= '0;
    end else begin
      req_sent_q <= req_sent_d;
      inflight_q <= inflight_d;
      cancel_q   <= cancel_d;
    end
  end

  a_no_underflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    data_sram_data_ok_i |-> (inflight_q != '0)
  );

endmodule

// File: tb/tb_exe_dmem_req.sv
// Randomized scoreboard bench for exe_dmem_req.
// Driver issues EXE/sram stimulus; monitor checks against a queue model.
module tb_exe_dmem_req;
  import exe_dmem_req_pkg::*;

  typedef struct {
    bit          stale;
    logic [31:0] rdata;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic        exe_valid_i;
  logic        exe_mem_req_i;
  logic        exe_we_i;
  logic [1:0]  exe_size_i;
  logic [31:0] exe_addr_i;
  logic [31:0] exe_wdata_i;
  logic        mem_allowin_i;
  logic        excep_flush_i;
  logic        data_sram_req_o;
  logic        data_sram_wr_o;
  logic [1:0]  data_sram_size_o;
  logic [3:0]  data_sram_wstrb_o;
  logic [31:0] data_sram_addr_o;
  logic [31:0] data_sram_wdata_o;
  logic        data_sram_addr_ok_i;
  logic        data_sram_data_ok_i;
  logic [31:0] data_sram_rdata_i;
  logic        exe_ready_go_o;
  logic        mem_data_ok_o;
  logic [31:0] mem_rdata_o;

  exe_dmem_req dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .exe_valid_i         (exe_valid_i),
    .exe_mem_req_i       (exe_mem_req_i),
    .exe_we_i            (exe_we_i),
    .exe_size_i          (exe_size_i),
    .exe_addr_i          (exe_addr_i),
    .exe_wdata_i         (exe_wdata_i),
    .mem_allowin_i       (mem_allowin_i),
    .excep_flush_i       (excep_flush_i),
    .data_sram_req_o     (data_sram_req_o),
    .data_sram_wr_o      (data_sram_wr_o),
    .data_sram_size_o    (data_sram_size_o),
    .data_sram_wstrb_o   (data_sram_wstrb_o),
    .data_sram_addr_o    (data_sram_addr_o),
    .data_sram_wdata_o   (data_sram_wdata_o),
    .data_sram_addr_ok_i (data_sram_addr_ok_i),
    .data_sram_data_ok_i (data_sram_data_ok_i),
    .data_sram_rdata_i   (data_sram_rdata_i),
    .exe_ready_go_o      (exe_ready_go_o),
    .mem_data_ok_o       (mem_data_ok_o),
    .mem_rdata_o         (mem_rdata_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ent_t exp_q[$];
  bit   m_sent;
  bit   need_new;
  bit   mon_en;
  int   n_checks;
  int   n_pass;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t",
                  nm, act, exp, $time);
  endtask

  function automatic logic [3:0] ref_strb(input logic we,
      input logic [1:0] sz, input logic [31:0] a);
    int nb;
    int m;
    if (!we) return 4'b0000;
    nb = 1 << sz;
    m = ((1 << nb) - 1) << a[1:0];
    return m[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] sz,
      input logic [31:0] d);
    int nb;
    logic [31:0] r;
    nb = 1 << sz;
    r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % nb) +: 8];
    return r;
  endfunction

  function automatic bit has_stale();
    foreach (exp_q[i]) if (exp_q[i].stale) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor: sampled 1 time unit after the driving edge.
  always @(negedge clk) begin
    bit   exp_req;
    bit   fire_m;
    bit   rg_m;
    ent_t e;
    #1;
    if (rst_n && mon_en) begin
      exp_req = exe_valid_i && exe_mem_req_i && !m_sent
             && !excep_flush_i && (exp_q.size() < DMEM_MAX_INFLIGHT)
             && !has_stale();
      chk("req", 32'(data_sram_req_o), 32'(exp_req));
      if (exp_req) begin
        chk("addr", data_sram_addr_o, exe_addr_i);
        chk("size", 32'(data_sram_size_o), 32'(exe_size_i));
        chk("wr", 32'(data_sram_wr_o), 32'(exe_we_i));
        chk("wstrb", 32'(data_sram_wstrb_o),
            32'(ref_strb(exe_we_i, exe_size_i, exe_addr_i)));
        if (exe_we_i)
          chk("wdata", data_sram_wdata_o,
              ref_wdata(exe_size_i, exe_wdata_i));
      end
      fire_m = exp_req && data_sram_addr_ok_i;
      rg_m = !exe_mem_req_i || m_sent || fire_m;
      chk("ready_go", 32'(exe_ready_go_o), 32'(rg_m));
      if (data_sram_data_ok_i && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("mem_data_ok", 32'(mem_data_ok_o), 32'(!e.stale));
        if (!e.stale) chk("mem_rdata", mem_rdata_o, e.rdata);
      end else begin
        chk("mem_data_ok_idle", 32'(mem_data_ok_o), 32'd0);
      end
      if (excep_flush_i)
        foreach (exp_q[i]) exp_q[i].stale = 1'b1;
      if (fire_m) begin
        e.stale = 1'b0;
        e.rdata = $urandom;
        exp_q.push_back(e);
      end
      if (excep_flush_i) m_sent = 1'b0;
      else if (exe_valid_i && rg_m && mem_allowin_i) m_sent = 1'b0;
      else if (fire_m) m_sent = 1'b1;
      if (excep_flush_i || !exe_valid_i ||
          (rg_m && mem_allowin_i))
        need_new = 1'b1;
    end
  end

  task automatic new_instr();
    logic [31:0] a;
    exe_valid_i   = ($urandom_range(0, 3) != 0);
    exe_mem_req_i = ($urandom_range(0, 4) != 0);
    exe_we_i      = 1'($urandom_range(0, 1));
    exe_size_i    = 2'($urandom_range(0, 2));
    a = $urandom;
    a = a & ~((32'd1 << exe_size_i) - 32'd1);
    exe_addr_i    = a;
    exe_wdata_i   = $urandom;
  endtask

  task automatic rand_cycle(input int p_dok, input int p_allow,
                            input int p_flush);
    @(negedge clk);
    if (need_new) begin
      new_instr();
      need_new = 1'b0;
    end
    mem_allowin_i = ($urandom_range(0, 99) < p_allow);
    excep_flush_i = ($urandom_range(0, 99) < p_flush);
    data_sram_addr_ok_i = 1'($urandom_range(0, 1));
    if (exp_q.size() > 0 && $urandom_range(0, 99) < p_dok) begin
      data_sram_data_ok_i = 1'b1;
      data_sram_rdata_i   = exp_q[0].rdata;
    end else begin
      data_sram_data_ok_i = 1'b0;
      data_sram_rdata_i   = $urandom;
    end
  endtask

  task automatic drain();
    @(negedge clk);
    exe_valid_i = 1'b0;
    excep_flush_i = 1'b1;
    data_sram_addr_ok_i = 1'b0;
    data_sram_data_ok_i = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      excep_flush_i = 1'b0;
      data_sram_data_ok_i = (exp_q.size() > 0);
      data_sram_rdata_i = (exp_q.size() > 0) ? exp_q[0].rdata : 32'd0;
    end
    @(negedge clk);
    data_sram_data_ok_i = 1'b0;
    chk("drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    m_sent   = 1'b0;
    need_new = 1'b1;
    mon_en   = 1'b0;
    rst_n    = 1'b0;
    exe_valid_i = 1'b1;
    exe_mem_req_i = 1'b0;
    exe_we_i = 1'b0;
    exe_size_i = SIZE_W;
    exe_addr_i = 32'h0;
    exe_wdata_i = 32'h0;
    mem_allowin_i = 1'b1;
    excep_flush_i = 1'b0;
    data_sram_addr_ok_i = 1'b1;
    data_sram_data_ok_i = 1'b1;
    data_sram_rdata_i = 32'hdead_beef;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_req", 32'(data_sram_req_o), 32'd0);
    chk("rst_ready_go", 32'(exe_ready_go_o), 32'd1);
    chk("rst_mem_data_ok", 32'(mem_data_ok_o), 32'd0);

    @(negedge clk);
    exe_valid_i = 1'b0;
    data_sram_data_ok_i = 1'b0;
    data_sram_addr_ok_i = 1'b0;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 2000; i++) rand_cycle(50, 70, 5);
    for (int i = 0; i < 1500; i++) rand_cycle(15, 30, 8);
    drain();

    // Load accepted and handed off, second load requesting, then reset.
    @(negedge clk);
    exe_valid_i = 1'b1;
    exe_mem_req_i = 1'b1;
    exe_we_i = 1'b0;
    exe_size_i = SIZE_W;
    exe_addr_i = 32'h0000_0100;
    mem_allowin_i = 1'b0;
    data_sram_addr_ok_i = 1'b1;
    @(negedge clk);
    mem_allowin_i = 1'b1;
    data_sram_addr_ok_i = 1'b0;
    @(negedge clk);
    exe_addr_i = 32'h0000_0104;
    mem_allowin_i = 1'b0;
    #1;
    chk("pre_rst_req", 32'(data_sram_req_o), 32'd1);
    chk("pre_rst_inflight", 32'(exp_q.size()), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", 32'(data_sram_req_o), 32'd0);
    chk("async_rst_mem_ok", 32'(mem_data_ok_o), 32'd0);
    exp_q.delete();
    m_sent = 1'b0;
    need_new = 1'b1;
    @(negedge clk);
    exe_valid_i = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 1500; i++) rand_cycle(40, 60, 3);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
